axi_lite_ram_slave: RTL
=======================

// Module: axi_lite_ram_slave
// PURPOSE
//  AXI4-Lite responder backing the core's load/store port: word-addressed
//  RAM behind the MMU bus, answering the ar/r and aw/w/b channels driven by
//  the mem stage. Read and write paths are independent FSMs sharing one RAM.
//  Used as the data memory in simulation and on FPGA.
// PARAMETERS
//  MEM_WORDS_LOG2  12  log2 of RAM depth in 32-bit words (16 KiB default)
//  WAIT_CYCLES     3   extra response delay, used only with AXI_SLAVE_WAIT_EN
// PORTS
//  clk          in   1   clock; all logic on posedge
//  rstn         in   1   reset, asynchronous, active-low
//  axi_araddr   in   32  read byte address
//  axi_arready  out  1   read address accept
//  axi_arvalid  in   1   read address valid
//  axi_arprot   in   3   ignored
//  axi_rdata    out  32  read data
//  axi_rready   in   1   master accepts read data
//  axi_rresp    out  2   2'b00 OKAY, 2'b10 SLVERR
//  axi_rvalid   out  1   read data valid
//  axi_awaddr   in   32  write byte address
//  axi_awready  out  1   write address accept
//  axi_awvalid  in   1   write address valid
//  axi_awprot   in   3   ignored
//  axi_wdata    in   32  write data
//  axi_wready   out  1   write data accept
//  axi_wstrb    in   4   byte enables, bit i -> wdata[8i+7:8i]
//  axi_wvalid   in   1   write data valid
//  axi_bready   in   1   master accepts write response
//  axi_bresp    out  2   2'b00 OKAY, 2'b10 SLVERR
//  axi_bvalid   out  1   write response valid
// BEHAVIOUR
//  Reset (rstn=0, async): both FSMs -> IDLE; rvalid=bvalid=0, rdata=0,
//   rresp=bresp=2'b00, arready=awready=wready=1, latched aw/w flags cleared.
//   RAM contents are NOT cleared. Reset mid-transaction drops it silently.
//  Decode: index=addr[MEM_WORDS_LOG2+1:2]; addr[1:0] ignored; in range iff
//   addr[31:MEM_WORDS_LOG2+2]==0. Out of range -> SLVERR, rdata=0, no write.
//  Read FSM R_IDLE -> R_DATA -> R_IDLE:
//   R_IDLE: arready=1. arvalid&&arready at edge T: latch addr, sync RAM read.
//   R_DATA: arready=0, rvalid=1 from T+1; rdata/rresp stable until
//    rvalid&&rready; that edge -> R_IDLE (arready=1 next cycle).
//   Max throughput one read per 2 cycles; rready may be high early.
//  Write FSM W_IDLE -> W_RESP -> W_IDLE:
//   W_IDLE: awready=!aw_held, wready=!w_held; aw and w captured independently
//    in any order or the same cycle. At the edge where both are held (or
//    arrive together) the strobed RAM write commits, next state W_RESP.
//   W_RESP: awready=wready=0, bvalid=1, bresp stable until bvalid&&bready;
//    then W_IDLE, held flags cleared. wstrb=4'b0000 -> OKAY, no byte changes.
//  Read/write collision (same word, same edge): read returns OLD data.
//  valid outputs never drop before their handshake.
// CONFIGURATION
//  AXI_SLAVE_WAIT_EN defined: extra states R_WAIT/W_WAIT; a counter loaded
//   with WAIT_CYCLES at AR handshake / write commit delays rvalid/bvalid by
//   exactly WAIT_CYCLES cycles (WAIT_CYCLES=0 equals undefined case); ready
//   outputs stay 0 while waiting. Read data captured at handshake, so writes
//   during the wait do not alter it. Used to stress the core's mem stage stalls.
//  Undefined: no wait states, latencies as above, WAIT_CYCLES unused.
// TESTING
//  1 aw 0x10 + w 0xDEADBEEF strb 4'hF same cycle, bready=1 -> bvalid 1 cycle
//    later, bresp 00; read 0x10 -> rvalid at T+1, rdata 0xDEADBEEF, rresp 00.
//  2 w before aw by 3 cycles (wdata 0x000000AA, strb 4'h1 at 0x10) -> wready
//    low after capture, one bvalid; read 0x10 -> 0xDEADBEAA.
//  3 read 0x0001_0000 (out of range, default) -> rresp 10, rdata 0; write
//    there -> bresp 10; RAM word 0 unchanged.
//  4 rready held 0 for 5 cycles after rvalid -> rvalid/rdata stable, arready 0,
//    new arvalid not accepted until handshake.
//  5 rstn pulsed low in R_DATA and W_RESP -> rvalid/bvalid 0 immediately;
//    after release reading 0x10 still returns prior data.
//  6 AXI_SLAVE_WAIT_EN, WAIT_CYCLES=3 -> rvalid at T+4, bvalid 4 cycles after
//    commit; same-word write during read wait does not alter returned rdata.

Source files
------------

// File: rtl/axi_lite_ram_slave_if.sv
// rtl/axi_lite_ram_slave_if.sv - AXI4-Lite bus bundle between the mem stage (master) and the data RAM (slave)
//
// Signals (direction seen from the slave modport):
//   ar channel : axi_araddr[31:0] in, axi_arprot[2:0] in, axi_arvalid in, axi_arready out
//   r  channel : axi_rdata[31:0] out, axi_rresp[1:0] out, axi_rvalid out, axi_rready in
//   aw channel : axi_awaddr[31:0] in, axi_awprot[2:0] in, axi_awvalid in, axi_awready out
//   w  channel : axi_wdata[31:0] in, axi_wstrb[3:0] in, axi_wvalid in, axi_wready out
//   b  channel : axi_bresp[1:0] out, axi_bvalid out, axi_bready in

interface axi_lite_ram_slave_if;
    logic [31:0] axi_araddr;
    logic        axi_arready;
    logic        axi_arvalid;
    logic [2:0]  axi_arprot;
    logic [31:0] axi_rdata;
    logic        axi_rready;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic [31:0] axi_awaddr;
    logic        axi_awready;
    logic        axi_awvalid;
    logic [2:0]  axi_awprot;
    logic [31:0] axi_wdata;
    logic        axi_wready;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_bready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;

    modport master (
        output axi_araddr, axi_arvalid, axi_arprot, axi_rready,
        output axi_awaddr, axi_awvalid, axi_awprot,
        output axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
        input  axi_arready, axi_rdata, axi_rresp, axi_rvalid,
        input  axi_awready, axi_wready, axi_bresp, axi_bvalid
    );

    modport slave (
        input  axi_araddr, axi_arvalid, axi_arprot, axi_rready,
        input  axi_awaddr, axi_awvalid, axi_awprot,
        input  axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
        output axi_arready, axi_rdata, axi_rresp, axi_rvalid,
        output axi_awready, axi_wready, axi_bresp, axi_bvalid
    );
endinterface

// File: rtl/axi_lite_ram_slave.sv
// rtl/axi_lite_ram_slave.sv - AXI4-Lite responder backed by a word-addressed RAM
//
// Ports:
//   clk  : clock, all logic on posedge
//   rstn : asynchronous active-low reset (RAM contents are kept)
//   axi  : axi_lite_ram_slave_if.slave - ar/r read path and aw/w/b write path
// Parameters:
//   MEM_WORDS_LOG2 : log2 of RAM depth in 32-bit words
//   WAIT_CYCLES    : extra rvalid/bvalid delay, only with AXI_SLAVE_WAIT_EN
// Build option:
//   AXI_SLAVE_WAIT_EN : adds R_WAIT/W_WAIT states delaying responses by WAIT_CYCLES

module axi_lite_ram_slave #(
    parameter int MEM_WORDS_LOG2 = 12,
    parameter int WAIT_CYCLES    = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    axi_lite_ram_slave_if.slave  axi
);

    localparam int         DEPTH       = 1 << MEM_WORDS_LOG2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXI_SLAVE_WAIT_EN
    localparam logic [7:0] CNT_LOAD    = 8'(WAIT_CYCLES);
`endif

    typedef enum logic [1:0] {
`ifdef AXI_SLAVE_WAIT_EN
        R_WAIT = 2'd2,
`endif
        R_IDLE = 2'd0,
        R_DATA = 2'd1
    } r_state_t;

    typedef enum logic [1:0] {
`ifdef AXI_SLAVE_WAIT_EN
        W_WAIT = 2'd2,
`endif
        W_IDLE = 2'd0,
        W_RESP = 2'd1
    } w_state_t;

    logic [31:0] mem [DEPTH];

    // ---------------------------------------------------------------- read path
    r_state_t                  r_state, r_next;
    logic                      arready_c, rvalid_c, ar_fire;
    logic [MEM_WORDS_LOG2-1:0] r_index;
    logic                      r_in_range;
    logic [31:0]               rdata_q;
    logic [1:0]                rresp_q;
`ifdef AXI_SLAVE_WAIT_EN
    logic [7:0]                r_cnt;
`endif

    assign r_index    = axi.axi_araddr[MEM_WORDS_LOG2+1:2];
    assign r_in_range = (axi.axi_araddr[31:MEM_WORDS_LOG2+2] == '0);
    assign arready_c  = (r_state == R_IDLE);
    assign rvalid_c   = (r_state == R_DATA);
    assign ar_fire    = axi.axi_arvalid && arready_c;

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: begin
                if (axi.axi_arvalid) begin
`ifdef AXI_SLAVE_WAIT_EN
                    r_next = (WAIT_CYCLES > 0) ? R_WAIT : R_DATA;
`else
                    r_next = R_DATA;
`endif
                end
            end
`ifdef AXI_SLAVE_WAIT_EN
            R_WAIT: begin
                if (r_cnt <= 8'd1) begin
                    r_next = R_DATA;
                end
            end
`endif
            R_DATA: begin
                if (axi.axi_rready) begin
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read data is captured at the AR handshake, so a write that commits on the
    // same edge (or during a wait period) never changes what is returned.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            r_state <= r_next;
            if (ar_fire) begin
                rdata_q <= r_in_range ? mem[r_index] : 32'd0;
                rresp_q <= r_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

`ifdef AXI_SLAVE_WAIT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (ar_fire) begin
            r_cnt <= CNT_LOAD;
        end else if (r_state == R_WAIT) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end
`endif

    assign axi.axi_arready = arready_c;
    assign axi.axi_rvalid  = rvalid_c;
    assign axi.axi_rdata   = rdata_q;
    assign axi.axi_rresp   = rresp_q;

    // --------------------------------------------------------------- write path
    w_state_t                  w_state, w_next;
    logic                      awready_c, wready_c, bvalid_c;
    logic                      aw_fire, w_fire, b_done, commit;
    logic                      aw_held, w_held;
    logic [31:0]               awaddr_q, wdata_q;
    logic [3:0]                wstrb_q;
    logic [31:0]               w_addr, w_data;
    logic [3:0]                w_strb;
    logic [MEM_WORDS_LOG2-1:0] w_index;
    logic                      w_in_range;
    logic [1:0]                bresp_q;
`ifdef AXI_SLAVE_WAIT_EN
    logic [7:0]                w_cnt;
`endif

    assign awready_c = (w_state == W_IDLE) && !aw_held;
    assign wready_c  = (w_state == W_IDLE) && !w_held;
    assign bvalid_c  = (w_state == W_RESP);
    assign aw_fire   = axi.axi_awvalid && awready_c;
    assign w_fire    = axi.axi_wvalid && wready_c;
    assign b_done    = bvalid_c && axi.axi_bready;

    // The commit uses whichever of address/data was latched earlier, or the
    // live bus value when that half arrives on the committing edge itself.
    assign w_addr     = aw_held ? awaddr_q : axi.axi_awaddr;
    assign w_data     = w_held  ? wdata_q  : axi.axi_wdata;
    assign w_strb     = w_held  ? wstrb_q  : axi.axi_wstrb;
    assign w_index    = w_addr[MEM_WORDS_LOG2+1:2];
    assign w_in_range = (w_addr[31:MEM_WORDS_LOG2+2] == '0);

    always_comb begin
        w_next = w_state;
        commit = 1'b0;
        case (w_state)
            W_IDLE: begin
                commit = (aw_held || aw_fire) && (w_held || w_fire);
                if (commit) begin
`ifdef AXI_SLAVE_WAIT_EN
                    w_next = (WAIT_CYCLES > 0) ? W_WAIT : W_RESP;
`else
                    w_next = W_RESP;
`endif
                end
            end
`ifdef AXI_SLAVE_WAIT_EN
            W_WAIT: begin
                if (w_cnt <= 8'd1) begin
                    w_next = W_RESP;
                end
            end
`endif
            W_RESP: begin
                if (axi.axi_bready) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state  <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= RESP_OKAY;
        end else begin
            w_state <= w_next;
            if (aw_fire) begin
                aw_held  <= 1'b1;
                awaddr_q <= axi.axi_awaddr;
            end
            if (w_fire) begin
                w_held  <= 1'b1;
                wdata_q <= axi.axi_wdata;
                wstrb_q <= axi.axi_wstrb;
            end
            if (commit) begin
                bresp_q <= w_in_range ? RESP_OKAY : RESP_SLVERR;
            end
            if (b_done) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

`ifdef AXI_SLAVE_WAIT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_cnt <= '0;
        end else if (commit) begin
            w_cnt <= CNT_LOAD;
        end else if (w_state == W_WAIT) begin
            w_cnt <= w_cnt - 8'd1;
        end
    end
`endif

    // RAM array has no reset; a commit seen while rstn is low is discarded.
    always_ff @(posedge clk) begin
        if (commit && w_in_range && rstn) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) begin
                    mem[w_index][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

    assign axi.axi_awready = awready_c;
    assign axi.axi_wready  = wready_c;
    assign axi.axi_bvalid  = bvalid_c;
    assign axi.axi_bresp   = bresp_q;

    logic unused_ok;
`ifdef AXI_SLAVE_WAIT_EN
    assign unused_ok = ^{axi.axi_arprot, axi.axi_awprot,
                         axi.axi_araddr[1:0], axi.axi_awaddr[1:0], w_addr[1:0]};
`else
    assign unused_ok = ^{axi.axi_arprot, axi.axi_awprot,
                         axi.axi_araddr[1:0], axi.axi_awaddr[1:0], w_addr[1:0],
                         32'(WAIT_CYCLES)};
`endif

endmodule
